// File: rtl/md_ctrl.sv
// md_ctrl: sequencer for the 32-step radix-2 restoring divider of the execute stage.
// Optional MD_SIGNED_EN enables signed (DIV) support; without it every divide is unsigned.
module md_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [64:0] work_q;
    logic [64:0] work_d;
    logic [31:0] divisor_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [32:0] diff_s;
    logic [31:0] op1_mag_s;
    logic [31:0] op2_mag_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;
    logic        unused_s;

`ifdef MD_SIGNED_EN
    logic        neg_quot_q;
    logic        neg_rem_q;

    assign unused_s = work_q[64];

    // Operand magnitudes at acceptance; sign fix-up of the finished result.
    always_comb begin
        op1_mag_s  = opdata1_i;
        op2_mag_s  = opdata2_i;
        quot_fix_s = work_d[31:0];
        rem_fix_s  = work_d[64:33];
        if (signed_i && opdata1_i[31]) begin
            op1_mag_s = 32'd0 - opdata1_i;
        end else begin
            op1_mag_s = opdata1_i;
        end
        if (signed_i && opdata2_i[31]) begin
            op2_mag_s = 32'd0 - opdata2_i;
        end else begin
            op2_mag_s = opdata2_i;
        end
        if (neg_quot_q) begin
            quot_fix_s = 32'd0 - work_d[31:0];
        end else begin
            quot_fix_s = work_d[31:0];
        end
        if (neg_rem_q) begin
            rem_fix_s = 32'd0 - work_d[64:33];
        end else begin
            rem_fix_s = work_d[64:33];
        end
    end
`else
    assign unused_s   = ^{work_q[64], signed_i};
    assign op1_mag_s  = opdata1_i;
    assign op2_mag_s  = opdata2_i;
    assign quot_fix_s = work_d[31:0];
    assign rem_fix_s  = work_d[64:33];
`endif

    // One restoring step: partial remainder sits in [63:32], quotient bits shift in at bit 0.
    always_comb begin
        diff_s = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        work_d = work_q;
        if (diff_s[32]) begin
            work_d = {work_q[63:0], 1'b0};
        end else begin
            work_d = {diff_s[31:0], work_q[31:0], 1'b1};
        end
    end

    // Controller FSM with registered result and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= 5'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
`ifdef MD_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (start_i && !annul_i) begin
                        cnt_q <= 5'd0;
                        if (opdata2_i == 32'd0) begin
                            work_q  <= {32'd0, opdata1_i, 1'b0};
                            state_q <= BY_ZERO;
                        end else begin
                            work_q     <= {32'd0, op1_mag_s, 1'b0};
                            divisor_q  <= op2_mag_s;
`ifdef MD_SIGNED_EN
                            neg_quot_q <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem_q  <= signed_i & opdata1_i[31];
`endif
                            state_q    <= ON;
                        end
                    end
                end
                BY_ZERO: begin
                    if (annul_i) begin
                        state_q <= FREE;
                    end else begin
                        result_q <= {work_q[32:1], 32'hFFFF_FFFF};
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        cnt_q    <= 5'd0;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                        state_q  <= FREE;
                    end else begin
                        work_q <= work_d;
                        if (cnt_q == 5'd31) begin
                            cnt_q    <= 5'd0;
                            result_q <= {rem_fix_s, quot_fix_s};
                            ready_q  <= 1'b1;
                            state_q  <= END;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                END: begin
                    if (!start_i || annul_i) begin
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                        state_q  <= FREE;
                    end
                end
                default: begin
                    cnt_q    <= 5'd0;
                    result_q <= 64'd0;
                    ready_q  <= 1'b0;
                    state_q  <= FREE;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl; expectations follow MD_SIGNED_EN when defined.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;

    md_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp, input int exp_lat,
                           input int hold);
        int lat;
        int stall_cnt;
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = sgn;
        start_i   = 1'b1;
        step();
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0000_0000;
        signed_i  = ~sgn;
        lat       = 0;
        stall_cnt = 0;
        while (ready_o !== 1'b1 && lat < 40) begin
            if (stallreq_o === 1'b1) stall_cnt++;
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
        chk({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_stall_drop"}, {63'd0, stallreq_o}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            chk({tag, "_hold_result"}, result_o, exp);
        end
        start_i = 1'b0;
        step();
        chk({tag, "_release_ready"}, {63'd0, ready_o}, 64'd0);
        chk({tag, "_release_result"}, result_o, 64'd0);
    endtask

    initial begin
        int ready_seen;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        annul_i   = 1'b0;
        step();
        step();
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
        rst = 1'b0;
        step();

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 32, 3);
`ifdef MD_SIGNED_EN
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 32, 1);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 32, 1);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 32, 1);
`else
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC, 32, 1);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h80000000_00000000, 32, 1);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000007_00000000, 32, 1);
`endif
        run_div("u1000_10", 32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 32, 1);
        run_div("u_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 64'h7FFFFFFE_00000001, 32, 0);
        run_div("div_zero", 32'h0000_1234, 32'd0, 1'b0, 64'h00001234_FFFFFFFF, 1, 1);

        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        signed_i  = 1'b0;
        start_i   = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        annul_i = 1'b1;
        step();
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        chk("annul_result", result_o, 64'd0);
        chk("annul_stall", {63'd0, stallreq_o}, 64'd1);
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o !== 1'b0) ready_seen++;
        end
        chk("annul_start_no_accept", 64'(ready_seen), 64'd0);
        chk("annul_hold_result", result_o, 64'd0);
        chk("annul_hold_stall", {63'd0, stallreq_o}, 64'd1);
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        chk("annul_stall_follows", {63'd0, stallreq_o}, 64'd0);
        step();

        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        rst     = 1'b1;
        start_i = 1'b0;
        step();
        chk("midrst_ready", {63'd0, ready_o}, 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_stall", {63'd0, stallreq_o}, 64'd0);
        step();
        chk("midrst_ready2", {63'd0, ready_o}, 64'd0);
        rst = 1'b0;
        step();
        run_div("after_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 32, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
